// File: rtl/pipelined_adder.sv
// Pipelined ripple adder/subtractor: N bits split into S chunks, one chunk per stage,
// with the carry registered between stages and a valid/ready handshake on both ends.

module pipelined_adder_stage #(
  parameter int N = 32,
  parameter int W = 8,
  parameter int K = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         vld_d,
  input  logic [N-1:0] a_d,
  input  logic [N-1:0] b_d,
  input  logic         c_d,
  input  logic [N-1:0] res_d,
  output logic         vld_q,
  output logic [N-1:0] a_q,
  output logic [N-1:0] b_q,
  output logic         c_q,
  output logic [N-1:0] res_q,
  output logic         ovf_q
);
  logic [W:0]   ch;
  logic [N-1:0] res_n;
  logic         ovf_n;

  assign ch = {1'b0, a_d[K*W +: W]} + {1'b0, b_d[K*W +: W]} + {{W{1'b0}}, c_d};

  always_comb begin
    res_n = res_d;
    res_n[K*W +: W] = ch[W-1:0];
  end

  // Carry into the MSB is recovered from the MSB sum bit; only meaningful in the top chunk.
  assign ovf_n = ch[W] ^ a_d[N-1] ^ b_d[N-1] ^ ch[W-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= 1'b0;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      vld_q <= vld_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= ch[W];
      res_q <= res_n;
      ovf_q <= ovf_n;
    end
  end
endmodule

module pipelined_adder #(
  parameter int N = 32,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  localparam int W = N / S;

  logic                stall;
  logic [S:0]          vld_pipe;
  logic [S-1:0][N-1:0] a_q, b_q, res_q;
  logic [S-1:0]        c_q, ovf_q;
  logic [N-1:0]        b_eff;
  logic                unused_ok;

  // Whole pipe freezes when the output beat is blocked; bubbles are never squeezed out.
  assign stall       = vld_pipe[S] & ~out_ready;
  assign in_ready    = ~stall;
  assign vld_pipe[0] = in_valid;
  assign b_eff       = sub ? ~b : b;

  for (genvar k = 0; k < S; k++) begin : g_stage
    if (k == 0) begin : g_first
      pipelined_adder_stage #(.N(N), .W(W), .K(k)) u_stage (
        .clk(clk), .rst_n(rst_n), .en(~stall),
        .vld_d(vld_pipe[0]), .a_d(a), .b_d(b_eff), .c_d(sub | cin), .res_d('0),
        .vld_q(vld_pipe[1]), .a_q(a_q[0]), .b_q(b_q[0]), .c_q(c_q[0]),
        .res_q(res_q[0]), .ovf_q(ovf_q[0])
      );
    end else begin : g_next
      pipelined_adder_stage #(.N(N), .W(W), .K(k)) u_stage (
        .clk(clk), .rst_n(rst_n), .en(~stall),
        .vld_d(vld_pipe[k]), .a_d(a_q[k-1]), .b_d(b_q[k-1]), .c_d(c_q[k-1]),
        .res_d(res_q[k-1]),
        .vld_q(vld_pipe[k+1]), .a_q(a_q[k]), .b_q(b_q[k]), .c_q(c_q[k]),
        .res_q(res_q[k]), .ovf_q(ovf_q[k])
      );
    end
  end

  assign out_valid = vld_pipe[S];
  assign sum       = res_q[S-1];
  assign cout      = c_q[S-1];
  assign ovf       = ovf_q[S-1];

  // Last-stage operand copies and lower-stage overflow flags have no consumer.
  assign unused_ok = ^{a_q[S-1], b_q[S-1], ovf_q};
endmodule
